// File: rtl/output_port_fifo_if.sv
// Handshake bundle between the control/bus logic and the output port FIFO.
// The master side pushes bus values and drains the head; the slave side is the FIFO.
`timescale 1ns/1ps
interface output_port_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             load;
  logic [WIDTH-1:0] bus_in;
  logic             out_ready;
  logic             clear_overflow;
  logic [WIDTH-1:0] out_val;
  logic             out_valid;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             overflow;

  modport master (
    output load, bus_in, out_ready, clear_overflow,
    input  out_val, out_valid, full, empty, count, overflow
  );

  modport slave (
    input  load, bus_in, out_ready, clear_overflow,
    output out_val, out_valid, full, empty, count, overflow
  );
endinterface

// File: rtl/output_port_fifo.sv
// DEPTH-entry FIFO behind the OUT instruction, with a minimum display hold per head
// value and last-value persistence on out_val once drained.
`timescale 1ns/1ps
module output_port_fifo #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 0
) (
  input logic               clk,
  input logic               reset,
  output_port_fifo_if.slave link
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [HW-1:0] HOLD_V = HW'(HOLD_CYCLES);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] last_val;
  logic [HW-1:0]    hold_cnt;
  logic             overflow_q;

  logic empty_w;
  logic full_w;
  logic valid_w;
  logic pop;
  logic push;
  logic new_head;

  assign empty_w  = (count_q == '0);
  assign full_w   = (count_q == CW'(DEPTH));
  assign valid_w  = ~empty_w & (hold_cnt == '0);
  assign pop      = valid_w & link.out_ready;
  assign push     = link.load & (~full_w | pop);
  // A fresh head appears on a push into an empty FIFO or a pop that leaves something behind.
  assign new_head = (push & empty_w) | (pop & ((count_q > CW'(1)) | push));

  // Storage is not reset: stale entries are never visible because count gates out_val.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= link.bus_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      last_val   <= '0;
      hold_cnt   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        last_val <= mem[rd_ptr];
      end
      if (push & ~pop)      count_q <= count_q + CW'(1);
      else if (pop & ~push) count_q <= count_q - CW'(1);
      if (new_head)             hold_cnt <= HOLD_V;
      else if (hold_cnt != '0)  hold_cnt <= hold_cnt - HW'(1);
      if (link.load & ~push)        overflow_q <= 1'b1;
      else if (link.clear_overflow) overflow_q <= 1'b0;
    end
  end

  assign link.out_val   = empty_w ? last_val : mem[rd_ptr];
  assign link.out_valid = valid_w;
  assign link.full      = full_w;
  assign link.empty     = empty_w;
  assign link.count     = count_q;
  assign link.overflow  = overflow_q;
endmodule

// File: tb/tb_output_port_fifo.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue model,
// on one instance without display hold and one with a 3-cycle hold.
`timescale 1ns/1ps
module tb_output_port_fifo;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  bit sel = 1'b0;

  output_port_fifo_if #(.WIDTH(8), .DEPTH(4)) if0 ();
  output_port_fifo_if #(.WIDTH(8), .DEPTH(4)) if3 ();

  output_port_fifo #(.WIDTH(8), .DEPTH(4), .HOLD_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .link(if0.slave));
  output_port_fifo #(.WIDTH(8), .DEPTH(4), .HOLD_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .link(if3.slave));

  always #5 clk = ~clk;

  logic [7:0] o_val;
  logic       o_valid, o_full, o_empty, o_ovf;
  logic [2:0] o_count;
  always_comb begin
    o_val   = sel ? if3.out_val   : if0.out_val;
    o_valid = sel ? if3.out_valid : if0.out_valid;
    o_full  = sel ? if3.full      : if0.full;
    o_empty = sel ? if3.empty     : if0.empty;
    o_ovf   = sel ? if3.overflow  : if0.overflow;
    o_count = sel ? if3.count     : if0.count;
  end

  // Reference model: a queue of pending values, the last popped value, and the
  // number of edges the current head has been on display.
  logic [7:0] mq[$];
  logic [7:0] m_last;
  bit         m_ovf;
  int         m_shown;
  bit         in_ld, in_rdy, in_clr;
  logic [7:0] in_d;
  logic [7:0] dut_pop[$];

  function automatic int m_hold();
    return sel ? 3 : 0;
  endfunction
  function automatic logic [7:0] e_val();
    return (mq.size() != 0) ? mq[0] : m_last;
  endfunction
  function automatic bit e_valid();
    return (mq.size() != 0) && (m_shown >= m_hold());
  endfunction

  task automatic drive(input bit ld, input logic [7:0] d, input bit rdy, input bit clr);
    in_ld = ld; in_d = d; in_rdy = rdy; in_clr = clr;
    if0.load = sel ? 1'b0 : ld;  if0.bus_in = d;
    if0.out_ready = sel ? 1'b0 : rdy;  if0.clear_overflow = sel ? 1'b0 : clr;
    if3.load = sel ? ld : 1'b0;  if3.bus_in = d;
    if3.out_ready = sel ? rdy : 1'b0;  if3.clear_overflow = sel ? clr : 1'b0;
  endtask

  task automatic tick();
    bit valid, pop, push;
    int old;
    if (o_valid && in_rdy) dut_pop.push_back(o_val);
    @(posedge clk);
    valid = e_valid();
    pop   = valid && in_rdy;
    push  = in_ld && (mq.size() < 4 || pop);
    old   = mq.size();
    if (pop) m_last = mq.pop_front();
    if (push) mq.push_back(in_d);
    if (in_ld && !push) m_ovf = 1'b1;
    else if (in_clr)    m_ovf = 1'b0;
    if ((push && old == 0) || (pop && mq.size() >= 1)) m_shown = 0;
    else if (m_shown < 1000) m_shown++;
    #1;
  endtask

  task automatic model_clear();
    mq.delete(); dut_pop.delete();
    m_last = 8'h00; m_ovf = 1'b0; m_shown = 0;
  endtask

  task automatic apply_reset();
    drive(0, 8'h00, 0, 0);
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    apply_reset();
    checks++; if (o_val !== 8'h00 || o_valid !== 1'b0 || o_empty !== 1'b1 || o_full !== 1'b0) begin
      failures++; $display("FAIL reset_outputs val=%h valid=%b empty=%b full=%b want 00 0 1 0", o_val, o_valid, o_empty, o_full); end
    checks++; if (o_count !== 3'd0 || o_ovf !== 1'b0) begin
      failures++; $display("FAIL reset_count count=%0d ovf=%b want 0 0", o_count, o_ovf); end
    drive(1, 8'h44, 0, 0); tick(); drive(0, 8'h00, 0, 0);
    checks++; if (o_val !== 8'h44 || o_valid !== 1'b1 || o_count !== 3'd1 || o_empty !== 1'b0) begin
      failures++; $display("FAIL first_load val=%h valid=%b count=%0d empty=%b want 44 1 1 0", o_val, o_valid, o_count, o_empty); end
  endtask

  task automatic test_overflow();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    sel = 1'b0;
    apply_reset();
    for (int i = 0; i < 4; i++) begin drive(1, vals[i], 0, 0); tick(); end
    checks++; if (o_full !== 1'b1 || o_count !== 3'd4) begin
      failures++; $display("FAIL fill full=%b count=%0d want 1 4", o_full, o_count); end
    drive(1, 8'h55, 0, 0); tick();
    checks++; if (o_count !== 3'd4 || o_ovf !== 1'b1 || o_val !== 8'h11) begin
      failures++; $display("FAIL drop count=%0d ovf=%b val=%h want 4 1 11", o_count, o_ovf, o_val); end
    drive(0, 8'h00, 1, 0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (o_val !== vals[i] || o_valid !== 1'b1) begin
        failures++; $display("FAIL drain_order[%0d] val=%h valid=%b want %h 1", i, o_val, o_valid, vals[i]); end
      tick();
    end
    tick();
    checks++; if (o_empty !== 1'b1 || o_val !== 8'h44 || o_valid !== 1'b0) begin
      failures++; $display("FAIL persist empty=%b val=%h valid=%b want 1 44 0", o_empty, o_val, o_valid); end
    drive(0, 8'h00, 0, 1); tick(); drive(0, 8'h00, 0, 0);
    checks++; if (o_ovf !== 1'b0) begin
      failures++; $display("FAIL clear_overflow ovf=%b want 0", o_ovf); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] want [4] = '{8'h22, 8'h33, 8'h44, 8'h66};
    sel = 1'b0;
    apply_reset();
    for (int i = 1; i <= 4; i++) begin drive(1, 8'(i * 8'h11), 0, 0); tick(); end
    drive(1, 8'h66, 1, 0); tick();
    checks++; if (o_count !== 3'd4 || o_ovf !== 1'b0 || o_val !== 8'h22) begin
      failures++; $display("FAIL full_push_pop count=%0d ovf=%b val=%h want 4 0 22", o_count, o_ovf, o_val); end
    drive(0, 8'h00, 1, 0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (o_val !== want[i]) begin
        failures++; $display("FAIL full_drain[%0d] val=%h want %h", i, o_val, want[i]); end
      tick();
    end
    checks++; if (o_empty !== 1'b1) begin
      failures++; $display("FAIL full_drain_empty empty=%b want 1", o_empty); end
  endtask

  task automatic test_hold();
    logic [7:0] wv;
    bit wvalid;
    sel = 1'b1;
    apply_reset();
    drive(1, 8'h22, 0, 0); tick();
    for (int k = 0; k < 10; k++) begin
      wv = (k < 4) ? 8'h22 : 8'h33;
      wvalid = (k == 3) || (k == 7);
      checks++; if (o_val !== wv || o_valid !== wvalid) begin
        failures++; $display("FAIL hold[%0d] val=%h valid=%b want %h %b", k, o_val, o_valid, wv, wvalid); end
      if (k == 0) drive(1, 8'h33, 1, 0); else drive(0, 8'h00, 1, 0);
      tick();
    end
    sel = 1'b0;
  endtask

  task automatic test_async_reset();
    sel = 1'b0;
    apply_reset();
    for (int i = 1; i <= 5; i++) begin drive(1, 8'(i * 8'h11), 0, 0); tick(); end
    drive(0, 8'h00, 1, 0); tick(); drive(0, 8'h00, 0, 0);
    checks++; if (o_count !== 3'd3 || o_ovf !== 1'b1) begin
      failures++; $display("FAIL pre_reset count=%0d ovf=%b want 3 1", o_count, o_ovf); end
    #1 reset = 1'b1;
    #1;
    model_clear();
    checks++; if (o_count !== 3'd0 || o_val !== 8'h00 || o_valid !== 1'b0 || o_ovf !== 1'b0 || o_empty !== 1'b1) begin
      failures++; $display("FAIL async_reset count=%0d val=%h valid=%b ovf=%b empty=%b want 0 00 0 0 1",
                           o_count, o_val, o_valid, o_ovf, o_empty); end
    @(negedge clk); reset = 1'b0;
    drive(1, 8'h5A, 0, 0); tick(); drive(0, 8'h00, 0, 0);
    checks++; if (o_val !== 8'h5A || o_count !== 3'd1 || o_valid !== 1'b1) begin
      failures++; $display("FAIL post_reset_load val=%h count=%0d valid=%b want 5a 1 1", o_val, o_count, o_valid); end
  endtask

  task automatic test_wrap();
    sel = 1'b0;
    apply_reset();
    for (int i = 1; i <= 10; i++) begin
      drive(1, 8'(i), 1, 0); tick();
      checks++; if (o_count > 3'd4 || o_count !== 3'(mq.size())) begin
        failures++; $display("FAIL wrap_count[%0d] count=%0d want %0d", i, o_count, mq.size()); end
    end
    drive(0, 8'h00, 1, 0);
    for (int i = 0; i < 6; i++) tick();
    checks++; if (dut_pop.size() != 10) begin
      failures++; $display("FAIL wrap_pops got=%0d want 10", dut_pop.size()); end
    for (int i = 0; i < dut_pop.size() && i < 10; i++) begin
      checks++; if (dut_pop[i] !== 8'(i + 1)) begin
        failures++; $display("FAIL wrap_order[%0d] got=%h want %h", i, dut_pop[i], 8'(i + 1)); end
    end
  endtask

  task automatic test_random(input bit use_hold);
    int ld_pct, rdy_pct;
    sel = use_hold;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      ld_pct  = (n < 200) ? 70 : 35;
      rdy_pct = (n < 200) ? 30 : 75;
      drive($urandom_range(0, 99) < ld_pct, 8'($urandom), $urandom_range(0, 99) < rdy_pct,
            $urandom_range(0, 99) < 6);
      tick();
      checks++; if (o_val !== e_val() || o_valid !== e_valid() || o_count !== 3'(mq.size()) ||
                    o_full !== (mq.size() == 4) || o_empty !== (mq.size() == 0) || o_ovf !== m_ovf) begin
        failures++;
        $display("FAIL random[h%0d,%0d] val=%h valid=%b count=%0d ovf=%b want %h %b %0d %b",
                 m_hold(), n, o_val, o_valid, o_count, o_ovf, e_val(), e_valid(), mq.size(), m_ovf);
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 8'h00, 0, 0);
    model_clear();
    #12;
    test_reset();
    test_overflow();
    test_full_push_pop();
    test_hold();
    test_async_reset();
    test_wrap();
    test_random(1'b0);
    test_random(1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded 200000 ns");
    $fatal(1, "timeout");
  end
endmodule
